// File: rtl/signal_gen_ctrl_pkg.sv
// Shared definitions for the square-wave / PWM generator: FSM state encoding and default widths.
// The measurement block uses the same CNT_W, so high/low times compare directly between the two.
package signal_gen_ctrl_pkg;

    localparam int DEF_CNT_W   = 20;
    localparam int DEF_BURST_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/signal_gen_ctrl_phase_down_counter.sv
// Loadable down-counter that times one phase; it is reloaded with (length-1) on each phase change.
// The zero flag marks the last clk of the phase, and the counter holds at zero once it gets there.
module phase_down_counter
    import signal_gen_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/signal_gen_ctrl.sv
// Programmable square-wave / PWM generator: Th clks high, Tl clks low, continuous or N-period burst.
// New settings are staged and only take effect at a period boundary, so no runt pulse is produced.
module signal_gen_ctrl
    import signal_gen_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int BURST_W  = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_load,
    input  logic [CNT_W-1:0]   high_time,
    input  logic [CNT_W-1:0]   low_time,
    input  logic [BURST_W-1:0] burst_len,
    output logic               sig_out,
    output logic               busy,
    output logic               period_done,
    output logic               finish,
    output logic [BURST_W-1:0] period_cnt
);

    // CLK_FREQ only documents the output frequency, CLK_FREQ / (Th + Tl).
    if (CLK_FREQ <= 0) begin : g_bad_clk_freq
    end

    state_t             state, next_state, first_state;
    logic               sig_q, pending;
    logic [CNT_W-1:0]   act_th, act_tl, stg_th, stg_tl, eff_th, eff_tl;
    logic [CNT_W-1:0]   first_val, load_val;
    logic [CNT_W:0]     eff_period;
    logic [BURST_W-1:0] act_bl, stg_bl, eff_bl, cnt_inc;
    logic               cnt_load, cnt_zero, start_go, apply_cfg, period_end, burst_done;

    // The config a new period starts with: staged values win when an update is pending.
    assign eff_th     = pending ? stg_th : act_th;
    assign eff_tl     = pending ? stg_tl : act_tl;
    assign eff_bl     = pending ? stg_bl : act_bl;
    assign eff_period = {1'b0, eff_th} + {1'b0, eff_tl};
    assign cnt_inc    = (&period_cnt) ? period_cnt : period_cnt + 1'b1;
    assign burst_done = (eff_bl != '0) && (cnt_inc >= eff_bl);

    always_comb begin : first_phase
        first_state = S_IDLE;
        first_val   = '0;
        if (eff_th != '0) begin
            first_state = S_HIGH;
            first_val   = eff_th - 1'b1;
        end else if (eff_tl != '0) begin
            first_state = S_LOW;
            first_val   = eff_tl - 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin : fsm_next
        next_state = state;
        cnt_load   = 1'b0;
        load_val   = '0;
        start_go   = 1'b0;
        apply_cfg  = 1'b0;
        period_end = 1'b0;
        case (state)
            S_IDLE: begin
                apply_cfg = pending;
                if (start && !stop && (eff_period != '0)) begin
                    start_go   = 1'b1;
                    next_state = first_state;
                    cnt_load   = 1'b1;
                    load_val   = first_val;
                end
            end
            S_HIGH: begin
                if (stop) begin
                    next_state = S_IDLE;
                end else if (cnt_zero) begin
                    if (act_tl != '0) begin
                        next_state = S_LOW;
                        cnt_load   = 1'b1;
                        load_val   = act_tl - 1'b1;
                    end else begin
                        period_end = 1'b1;
                    end
                end
            end
            S_LOW: begin
                if (stop) begin
                    next_state = S_IDLE;
                end else if (cnt_zero) begin
                    period_end = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase

        // Period boundary: pick up any staged config, then finish the burst or start the next period.
        if (period_end) begin
            apply_cfg = pending;
            if (burst_done) begin
                next_state = S_IDLE;
            end else begin
                next_state = first_state;
                cnt_load   = 1'b1;
                load_val   = first_val;
            end
        end
    end

    // NOTE: only control and config registers are reset; there is no memory array to clear here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sig_q      <= 1'b0;
            period_cnt <= '0;
            act_th     <= '0;
            act_tl     <= '0;
            act_bl     <= '0;
            stg_th     <= '0;
            stg_tl     <= '0;
            stg_bl     <= '0;
            pending    <= 1'b0;
        end else begin
            state <= next_state;
            sig_q <= (next_state == S_HIGH);
            if (start_go) begin
                period_cnt <= '0;
            end else if (period_end) begin
                period_cnt <= cnt_inc;
            end
            if (apply_cfg) begin
                act_th  <= stg_th;
                act_tl  <= stg_tl;
                act_bl  <= stg_bl;
                pending <= 1'b0;
            end
            // A load landing on the same edge as an apply stays pending for the next boundary.
            if (cfg_load) begin
                stg_th  <= high_time;
                stg_tl  <= low_time;
                stg_bl  <= burst_len;
                pending <= 1'b1;
            end
        end
    end

    phase_down_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    assign sig_out     = sig_q;
    assign busy        = (state != S_IDLE);
    assign period_done = period_end;
    assign finish      = period_end && burst_done;

endmodule

// File: tb/tb_signal_gen_ctrl.sv
// Bench for signal_gen_ctrl: directed scenarios plus random traffic, each cycle checked against a
// model that expands every period into a queue of output levels (Th ones followed by Tl zeros).
module tb_signal_gen_ctrl;

    localparam int CNT_W   = 20;
    localparam int BURST_W = 4;
    localparam int CNT_MAX = (1 << BURST_W) - 1;

    logic               clk = 1'b0;
    logic               rst, start, stop, cfg_load;
    logic [CNT_W-1:0]   high_time, low_time;
    logic [BURST_W-1:0] burst_len;
    logic               sig_out, busy, period_done, finish;
    logic [BURST_W-1:0] period_cnt;

    int checks = 0;
    int errors = 0;
    int pd_seen, fin_seen;

    signal_gen_ctrl #(
        .CLK_FREQ (50_000_000),
        .CNT_W    (CNT_W),
        .BURST_W  (BURST_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_load    (cfg_load),
        .high_time   (high_time),
        .low_time    (low_time),
        .burst_len   (burst_len),
        .sig_out     (sig_out),
        .busy        (busy),
        .period_done (period_done),
        .finish      (finish),
        .period_cnt  (period_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: running flag, queue of remaining output levels in the current period,
    // completed-period count, and active / staged configuration.
    bit m_run, m_pend;
    int m_q[$];
    int m_cnt;
    int a_th, a_tl, a_bl, s_th, s_tl, s_bl;

    function automatic void m_fill(input int th, input int tl);
        m_q.delete();
        for (int i = 0; i < th; i++) m_q.push_back(1);
        for (int i = 0; i < tl; i++) m_q.push_back(0);
        m_run = (m_q.size() != 0);
    endfunction

    function automatic int m_next_cnt();
        return (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
    endfunction

    function automatic void m_apply();
        if (m_pend) begin
            a_th   = s_th;
            a_tl   = s_tl;
            a_bl   = s_bl;
            m_pend = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit r, input bit st, input bit sp, input bit cl,
                                       input int th, input int tl, input int bl);
        if (r) begin
            m_run = 1'b0; m_q.delete(); m_cnt = 0; m_pend = 1'b0;
            a_th = 0; a_tl = 0; a_bl = 0; s_th = 0; s_tl = 0; s_bl = 0;
            return;
        end
        if (!m_run) begin
            m_apply();
            if (st && !sp && (a_th + a_tl) != 0) begin
                m_cnt = 0;
                m_fill(a_th, a_tl);
            end
        end else if (sp) begin
            m_run = 1'b0;
            m_q.delete();
        end else if (m_q.size() == 1) begin
            m_cnt = m_next_cnt();
            m_apply();
            if (a_bl != 0 && m_cnt >= a_bl) begin
                m_run = 1'b0;
                m_q.delete();
            end else begin
                m_fill(a_th, a_tl);
            end
        end else begin
            void'(m_q.pop_front());
        end
        if (cl) begin
            s_th = th; s_tl = tl; s_bl = bl;
            m_pend = 1'b1;
        end
    endfunction

    // One clock cycle: drive inputs, compare at the falling edge, advance the model after the rising edge.
    task automatic step(input bit r, input bit st, input bit sp, input bit cl,
                        input int th, input int tl, input int bl);
        bit last, pd, fin;
        int e_bl, exp_sig;
        rst       = r;
        start     = st;
        stop      = sp;
        cfg_load  = cl;
        high_time = CNT_W'(th);
        low_time  = CNT_W'(tl);
        burst_len = BURST_W'(bl);
        @(negedge clk);
        e_bl    = m_pend ? s_bl : a_bl;
        last    = m_run && (m_q.size() == 1);
        pd      = last && !sp;
        fin     = pd && (e_bl != 0) && (m_next_cnt() >= e_bl);
        exp_sig = m_run ? m_q[0] : 0;
        check("sig_out", sig_out, exp_sig);
        check("busy", busy, m_run);
        check("period_done", period_done, pd);
        check("finish", finish, fin);
        check("period_cnt", period_cnt, m_cnt);
        pd_seen  += int'(period_done === 1'b1);
        fin_seen += int'(finish === 1'b1);
        @(posedge clk);
        #1;
        model_edge(r, st, sp, cl, th, tl, bl);
    endtask

    task automatic run(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_and_start(input int th, input int tl, input int bl);
        step(0, 0, 0, 1, th, tl, bl);
        step(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_load = 1'b0;
        high_time = '0; low_time = '0; burst_len = '0;
        pd_seen = 0; fin_seen = 0;
        @(posedge clk);
        #1;
        model_edge(1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0);
        run(2);

        // 40/60 burst of 8: 100-clk period, 8 period_done pulses, one finish.
        pd_seen = 0; fin_seen = 0;
        load_and_start(40, 60, 8);
        run(810);
        check("t1_period_done_pulses", pd_seen, 8);
        check("t1_finish_pulses", fin_seen, 1);
        check("t1_final_cnt", period_cnt, 8);

        // Continuous run, retuned mid-period; the change lands at the next boundary.
        load_and_start(10, 8, 0);
        run(25);
        step(0, 0, 0, 1, 7, 5, 0);
        run(60);
        step(0, 0, 1, 0, 0, 0, 0);
        run(2);

        // Corners: 1/1 toggle, Th=0, Tl=0, Th=Tl=0, and period_cnt saturation.
        load_and_start(1, 1, 0);
        run(10);
        step(0, 0, 1, 0, 0, 0, 0);
        load_and_start(0, 10, 0);
        pd_seen = 0;
        run(30);
        check("t4_th0_pulses", pd_seen, 3);
        step(0, 0, 1, 0, 0, 0, 0);
        load_and_start(3, 0, 0);
        run(12);
        step(0, 0, 1, 0, 0, 0, 0);
        load_and_start(0, 0, 0);
        run(5);
        load_and_start(1, 1, 0);
        run(40);
        check("t4_saturated_cnt", period_cnt, CNT_MAX);
        step(0, 0, 1, 0, 0, 0, 0);

        // Stop during HIGH, coincident stop+start, then a clean restart.
        load_and_start(5, 5, 0);
        run(2);
        step(0, 0, 1, 0, 0, 0, 0);
        run(2);
        step(0, 1, 0, 0, 0, 0, 0);
        run(3);
        step(0, 1, 1, 0, 0, 0, 0);
        run(2);
        step(0, 1, 0, 0, 0, 0, 0);
        run(12);
        step(0, 0, 1, 0, 0, 0, 0);

        // Reset mid-LOW, then start with a cleared active config.
        load_and_start(4, 6, 0);
        run(6);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        run(5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
